// File: rtl/pipelined_multiplier_8x8.sv
// Unsigned 8x8 multiplier, three register stages: operand capture, pairwise
// partial-product sums, final sum. A new operand pair is accepted every clock.
module pipelined_multiplier_8x8 (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic [15:0] P
);

  logic [7:0]       a_d, a_q;
  logic [7:0]       b_d, b_q;
  logic [3:0][15:0] s_d, s_q;
  logic [15:0]      p_d, p_q;
  logic [7:0][15:0] pp;

  // NOTE: every always_comb output is fully assigned on every pass, so no latches are inferred.
  always_comb begin
    a_d = A;
    b_d = B;
    for (int i = 0; i < 8; i++) begin
      pp[i] = b_q[i] ? ({8'h00, a_q} << i) : 16'h0000;
    end
    for (int j = 0; j < 4; j++) begin
      s_d[j] = pp[2*j] + pp[2*j+1];
    end
    p_d = (s_q[0] + s_q[1]) + (s_q[2] + s_q[3]);
  end

  // NOTE: state updates use non-blocking assignments so all stages shift in lockstep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
      p_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
      p_q <= p_d;
    end
  end

  assign P = p_q;

endmodule

// File: tb/tb_pipelined_multiplier_8x8.sv
// Self-checking bench for pipelined_multiplier_8x8: reset behaviour, timed
// streaming sequence, table-driven extremes, mid-stream reset, random stream.
module tb_pipelined_multiplier_8x8;

  logic        clk;
  logic        rst;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [15:0] P;

  int checks;
  int errors;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[8];

  pipelined_multiplier_8x8 dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .P   (P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic at(input time t);
    #(t - $time);
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    A = a;
    B = b;
  endtask

  task automatic edge_then_sample;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] m0, m1, m2;
  logic [7:0]  ra, rb;

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{a: 8'd255, b: 8'd255, p: 16'd65025};
    vecs[1] = '{a: 8'd0,   b: 8'd255, p: 16'd0};
    vecs[2] = '{a: 8'd1,   b: 8'd200, p: 16'd200};
    vecs[3] = '{a: 8'd128, b: 8'd2,   p: 16'd256};
    vecs[4] = '{a: 8'd255, b: 8'd1,   p: 16'd255};
    vecs[5] = '{a: 8'd170, b: 8'd85,  p: 16'd14450};
    vecs[6] = '{a: 8'd16,  b: 8'd16,  p: 16'd256};
    vecs[7] = '{a: 8'd3,   b: 8'd7,   p: 16'd21};

    // Timed streaming sequence: edges at 5, 15, 25, ...
    rst = 1'b1;
    A   = 8'd0;
    B   = 8'd0;
    at(3);  check("reset_p", P, 16'd0);
    at(12); rst = 1'b0;
    at(22); A = 8'd15;  B = 8'd10;
    at(24); check("stream_t24", P, 16'd0);
    at(32); A = 8'd25;  B = 8'd12;
    at(34); check("stream_t34", P, 16'd0);
    at(42); A = 8'd50;  B = 8'd20;
    at(44); check("stream_t44", P, 16'd0);
    at(46); check("stream_150", P, 16'd150);
    at(52); A = 8'd100; B = 8'd5;
    at(56); check("stream_300", P, 16'd300);
    at(62); A = 8'd200; B = 8'd3;
    at(66); check("stream_1000", P, 16'd1000);
    at(76); check("stream_500", P, 16'd500);
    at(86); check("stream_600", P, 16'd600);

    // Asynchronous reset between edges with maximal operands.
    at(90);  rst = 1'b1; A = 8'hFF; B = 8'hFF;
    at(91);  check("async_rst_immediate", P, 16'd0);
    at(96);  check("in_rst_t96", P, 16'd0);
    at(106); check("in_rst_t106", P, 16'd0);
    at(116); check("in_rst_t116", P, 16'd0);
    at(120); A = 8'd0; B = 8'd0;
    at(122); rst = 1'b0;
    for (int t = 126; t <= 156; t += 10) begin
      at(t);
      check($sformatf("post_rst_zero_t%0d", t), P, 16'd0);
    end

    // Table-driven extremes, back to back; result must land exactly 2 edges later.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i < 8) begin
        A = vecs[i].a;
        B = vecs[i].b;
      end else begin
        A = 8'd7;
        B = 8'd9;
      end
      edge_then_sample();
      if (i >= 2) check($sformatf("vec%0d", i - 2), P, vecs[i-2].p);
      else        check($sformatf("vec_early%0d", i), P, 16'd0);
    end
    edge_then_sample();
    check("hold_63", P, 16'd63);

    // Mid-stream reset: (15,10) and (25,12) in flight, must never emerge.
    drive(8'd15, 8'd10);
    edge_then_sample();
    check("mid_before_a", P, 16'd63);
    drive(8'd25, 8'd12);
    edge_then_sample();
    check("mid_before_b", P, 16'd63);
    rst = 1'b1;
    #1;
    check("mid_rst_immediate", P, 16'd0);
    @(negedge clk);
    A = 8'd0;
    B = 8'd0;
    #2;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      edge_then_sample();
      check($sformatf("mid_discard%0d", i), P, 16'd0);
    end
    drive(8'd9, 8'd11);
    edge_then_sample();
    check("mid_new_e0", P, 16'd0);
    drive(8'd0, 8'd0);
    edge_then_sample();
    check("mid_new_e1", P, 16'd0);
    edge_then_sample();
    check("mid_new_e2", P, 16'd99);
    edge_then_sample();
    edge_then_sample();

    // Random stream against a 3-deep reference pipeline (pipeline currently all zero).
    m0 = '0;
    m1 = '0;
    m2 = '0;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(255));
      rb = 8'($urandom_range(255));
      drive(ra, rb);
      edge_then_sample();
      m2 = m1;
      m1 = m0;
      m0 = 16'(ra) * 16'(rb);
      check($sformatf("rand%0d", i), P, m2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
